// File: rtl/mtsp_cache_pkg.sv
// Shared types and helpers for the MTSP cache lookup sequencer.
//   state_e          : sequencer FSM states
//   tag_width()      : tag bits left after index and line offset
//   line_beats()     : memory beats per cache line
//   beat_cnt_width() : width of the fill beat counter
//   addr_index/addr_tag/addr_line : byte-address split helpers (64-bit carriers,
//                      callers truncate to their own widths)
package mtsp_cache_pkg;

  typedef enum logic [2:0] {
    S_SETTLE,
    S_IDLE,
    S_LOOK,
    S_WAIT,
    S_RESOLVE,
    S_FILL_REQ,
    S_FILL_DATA,
    S_DONE
  } state_e;

  function automatic int tag_width(input int addr_w, input int lut_w, input int line_w);
    return addr_w - lut_w - line_w;
  endfunction

  function automatic int line_beats(input int line_w, input int data_w);
    return ((1 << line_w) * 8) / data_w;
  endfunction

  // Never narrower than one bit so a single-beat line still elaborates.
  function automatic int beat_cnt_width(input int line_w, input int data_w);
    int b;
    b = line_beats(line_w, data_w);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a, input int line_w, input int lut_w);
    return (a >> line_w) & ((64'd1 << lut_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int line_w, input int lut_w);
    return a >> (line_w + lut_w);
  endfunction

  function automatic logic [63:0] addr_line(input logic [63:0] a, input int line_w);
    return a & ~((64'd1 << line_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mtsp_cache_lookup_sva.sv
// Protocol checks for mtsp_cache_lookup, attached by bind.
//   clk, rst : DUT clock and reset
//   state    : DUT FSM state
//   lut_ack  : LUT result valid (must be present in RESOLVE)
//   lut_req  : lookup pulse (must be low in RESOLVE so the LUT can write the tag)
module mtsp_cache_lookup_sva
  import mtsp_cache_pkg::*;
(
  input logic   clk,
  input logic   rst,
  input state_e state,
  input logic   lut_ack,
  input logic   lut_req
);

  a_ack_in_resolve: assert property (@(posedge clk) disable iff (rst)
    (state == S_RESOLVE) |-> lut_ack);

  a_no_req_in_resolve: assert property (@(posedge clk) disable iff (rst)
    (state == S_RESOLVE) |-> !lut_req);

endmodule

bind mtsp_cache_lookup mtsp_cache_lookup_sva u_sva (
  .clk     (clk),
  .rst     (rst),
  .state   (state),
  .lut_ack (lut_ack),
  .lut_req (lut_req)
);

// File: rtl/mtsp_cache_lookup.sv
// Upstream sequencer for the MTSP cache tag LUT.
// Accepts one outstanding load at a time, runs the 2-cycle tag lookup, and on a
// miss fetches the line into the cache data RAM before responding. Also owns LUT
// clearing (post-reset settle window and explicit invalidates).
// Ports:
//   clk, rst                    : clock, async active-high reset
//   req_valid/req_addr/req_ready: load request (ready only in IDLE, not while invalidating)
//   inv_req                     : whole-LUT invalidate, level, sampled in IDLE
//   rsp_done/rsp_hit            : completion pulse, hit(1) or filled(0)
//   lut_clear                   : one-cycle LUT clear start
//   lut_req/lut_addr/lut_data   : lookup pulse, index and tag
//   lut_ack/lut_hit             : lookup result
//   mem_req/mem_addr/mem_grant  : line read request, held until granted
//   mem_rvalid/mem_rdata        : read beats
//   cd_we/cd_addr/cd_data       : registered cache data RAM write port
module mtsp_cache_lookup
  import mtsp_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LUT_W  = 6,
  parameter int LINE_W = 5,
  parameter int DATA_W = 32,
  localparam int TAG_W  = tag_width(ADDR_W, LUT_W, LINE_W),
  localparam int BEATS  = line_beats(LINE_W, DATA_W),
  localparam int BCNT_W = beat_cnt_width(LINE_W, DATA_W),
  localparam int CD_AW  = LUT_W + LINE_W - $clog2(DATA_W / 8)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              inv_req,
  output logic              rsp_done,
  output logic              rsp_hit,
  output logic              lut_clear,
  output logic              lut_req,
  output logic [LUT_W-1:0]  lut_addr,
  output logic [TAG_W-1:0]  lut_data,
  input  logic              lut_ack,
  input  logic              lut_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cd_we,
  output logic [CD_AW-1:0]  cd_addr,
  output logic [DATA_W-1:0] cd_data
);

  localparam logic [LUT_W:0]    SETTLE_LAST = (LUT_W + 1)'((1 << LUT_W) - 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST   = BCNT_W'(BEATS - 1);

  state_e              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                hit_q;
  logic [LUT_W:0]      settle_cnt;
  logic [BCNT_W-1:0]   beat_cnt;
  logic                last_q;   // last beat was captured; its CD write is out this cycle
  logic                accept;
  logic                beat_take;

  // Invalidate wins over a request in the same IDLE cycle.
  assign accept    = (state == S_IDLE) && !inv_req && req_valid;
  // Beats arriving after the line is complete (or outside the fill) are dropped.
  assign beat_take = (state == S_FILL_DATA) && mem_rvalid && !last_q;

  // Index/tag/line base come from the latched address so they hold steady
  // from LOOK through RESOLVE and for the whole fill.
  assign lut_addr = LUT_W'(addr_index(64'(addr_q), LINE_W, LUT_W));
  assign lut_data = TAG_W'(addr_tag(64'(addr_q), LINE_W, LUT_W));
  assign mem_addr = ADDR_W'(addr_line(64'(addr_q), LINE_W));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_SETTLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_SETTLE:    if (settle_cnt == SETTLE_LAST) state_next = S_IDLE;
      S_IDLE: begin
        if (inv_req)        state_next = S_SETTLE;
        else if (req_valid) state_next = S_LOOK;
      end
      S_LOOK:      state_next = S_WAIT;
      S_WAIT:      state_next = S_RESOLVE;
      // A missing ack is treated as a miss; the bound assertion reports it.
      S_RESOLVE:   state_next = (lut_ack && lut_hit) ? S_DONE : S_FILL_REQ;
      S_FILL_REQ:  if (mem_grant) state_next = S_FILL_DATA;
      // Leave one cycle after the last beat so the final CD write precedes done.
      S_FILL_DATA: if (last_q) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_SETTLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    lut_clear = 1'b0;
    lut_req   = 1'b0;
    mem_req   = 1'b0;
    rsp_done  = 1'b0;
    rsp_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = !inv_req;
        lut_clear = inv_req;
      end
      S_LOOK:     lut_req = 1'b1;
      S_FILL_REQ: mem_req = 1'b1;
      S_DONE: begin
        rsp_done = 1'b1;
        rsp_hit  = hit_q;
      end
      default: ;
    endcase
  end

  // Request latch and lookup result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      if (accept)               addr_q <= req_addr;
      if (state == S_RESOLVE)   hit_q  <= lut_ack && lut_hit;
    end
  end

  // Settle counter: zero outside SETTLE, so every SETTLE entry starts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  settle_cnt <= '0;
    else if (state == S_SETTLE && state_next == S_SETTLE)
                              settle_cnt <= settle_cnt + 1'b1;
    else                      settle_cnt <= '0;
  end

  // Fill beat counter and registered cache data write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      last_q   <= 1'b0;
      cd_we    <= 1'b0;
      cd_addr  <= '0;
      cd_data  <= '0;
    end else begin
      if (state == S_FILL_REQ) beat_cnt <= '0;
      else if (beat_take)      beat_cnt <= beat_cnt + 1'b1;
      last_q <= beat_take && (beat_cnt == BEAT_LAST);
      cd_we  <= beat_take;
      if (beat_take) begin
        cd_addr <= CD_AW'({lut_addr, beat_cnt});
        cd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mtsp_cache_lookup.sv
// Directed bench for mtsp_cache_lookup. Inputs change 1 time unit after the
// rising edge; outputs are compared on the falling edge. Cycle k is the interval
// after the k-th rising edge. A transaction-level model (expected event cycles,
// address split by arithmetic, queue of expected cache writes) is checked every
// cycle, plus a few hand-computed literals.
module tb_mtsp_cache_lookup;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        inv_req = 1'b0;
  logic        rsp_done, rsp_hit, lut_clear, lut_req;
  logic [5:0]  lut_addr;
  logic [20:0] lut_data;
  logic        lut_ack = 1'b0;
  logic        lut_hit = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cd_we;
  logic [8:0]  cd_addr;
  logic [31:0] cd_data;

  mtsp_cache_lookup dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .inv_req(inv_req), .rsp_done(rsp_done), .rsp_hit(rsp_hit),
    .lut_clear(lut_clear), .lut_req(lut_req), .lut_addr(lut_addr), .lut_data(lut_data),
    .lut_ack(lut_ack), .lut_hit(lut_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cd_we(cd_we), .cd_addr(cd_addr), .cd_data(cd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [5:0]  idx_of(input logic [31:0] a);  return a[10:5];           endfunction
  function automatic logic [20:0] tag_of(input logic [31:0] a);  return a[31:11];          endfunction
  function automatic logic [31:0] line_of(input logic [31:0] a); return a & 32'hFFFF_FFE0; endfunction

  logic [31:0] m_addr = '0;
  logic        exp_hit = 1'b0;
  logic        cfg_hit = 1'b0;
  int          exp_lreq = -1;
  int          exp_done = -1;
  int          exp_clr  = -1;
  int          mreq_lo  = 1;
  int          mreq_hi  = 0;
  int          idle_at  = 0;
  int          wr_n     = 0;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    exp_lreq = -1; exp_done = -1; exp_clr = -1;
    mreq_lo = 1; mreq_hi = 0; wr_n = 0;
    exp_q.delete();
  endtask

  // LUT responder: ack two cycles after each lookup pulse.
  logic p0 = 1'b0, p1 = 1'b0;
  always @(posedge clk) begin
    #1;
    lut_ack = p1;
    lut_hit = p1 & cfg_hit;
    p1 = p0;
    p0 = lut_req;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("lut_req_time", lut_req, cyc == exp_lreq);
      if (exp_lreq >= 0 && cyc >= exp_lreq && cyc <= exp_lreq + 2) begin
        chk("lut_addr", lut_addr, idx_of(m_addr));
        chk("lut_data", lut_data, tag_of(m_addr));
      end
      chk("rsp_done_time", rsp_done, cyc == exp_done);
      if (rsp_done) chk("rsp_hit", rsp_hit, exp_hit);
      chk("lut_clear_time", lut_clear, cyc == exp_clr);
      chk("mem_req_window", mem_req, cyc >= mreq_lo && cyc <= mreq_hi);
      if (mem_req) chk("mem_addr", mem_addr, line_of(m_addr));
      if (cd_we) begin
        if (exp_q.size() == 0) chk("cd_we_unexpected", 1'b1, 1'b0);
        else begin
          chk("cd_data", cd_data, exp_q.pop_front());
          chk("cd_addr", cd_addr, {idx_of(m_addr), 3'(wr_n)});
          wr_n++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 5000) begin step(); g++; end
    if (cyc != c) chk("goto_bound", 64'(cyc), 64'(c));
  endtask

  // Issue one load. Accept cycle A comes from the model (first idle cycle).
  // Miss: grant after gw extra MEM_REQ cycles, beats per slot mask, stops after nb beats.
  task automatic issue(input logic [31:0] a, input logic hit, input int gw,
                       input logic [8:0] slots, input int nb, output int acc);
    int n, last;
    acc = (cyc > idle_at) ? cyc : idle_at;
    req_valid = 1'b1;
    req_addr  = a;
    goto(acc);
    m_addr = a; exp_hit = hit; cfg_hit = hit; wr_n = 0;
    exp_lreq = acc + 1; mreq_lo = 1; mreq_hi = 0;
    chk("req_ready_at_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (hit) begin
      exp_done = acc + 4;
      idle_at  = acc + 5;
    end else begin
      mreq_lo = acc + 4;
      mreq_hi = acc + 4 + gw;
      goto(acc + 4 + gw);
      mem_grant = 1'b1;
      step();
      mem_grant = 1'b0;
      n = 0; last = cyc;
      for (int s = 0; s < 9 && n < nb; s++) begin
        if (slots[s]) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
          exp_q.push_back(mem_rdata);
          n++; last = cyc;
        end else mem_rvalid = 1'b0;
        step();
      end
      mem_rvalid = 1'b0;
      if (nb == 8) begin
        exp_done = last + 2;
        idle_at  = last + 3;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    int a, t, r;
    // Reset values
    step(); step();
    chk("rst_ctrl_outs", {req_ready, rsp_done, rsp_hit, lut_clear, lut_req, mem_req, cd_we}, 7'b0);
    chk("rst_addr_outs", {lut_addr, lut_data, mem_addr, cd_addr}, 68'h0);
    chk("rst_cd_data", cd_data, 32'h0);

    // Release with a request already pending. Release cycle is cycle 1 of the
    // settle window: ready low for 64 cycles, accept at 65, lookup at 66.
    req_valid = 1'b1;
    req_addr  = 32'h0000_07E0;
    rst = 1'b0;
    r = cyc;
    idle_at = r + 64;
    for (int k = 0; k < 64; k++) begin
      goto(r + k);
      chk("ready_low_settle", req_ready, 1'b0);
    end
    issue(32'h0000_07E0, 1'b1, 0, 9'h0, 0, a);
    chk("first_lut_req", lut_req, 1'b1);
    chk("first_lut_addr", lut_addr, 6'h3F);

    // Hit on 0x0001_2340: index 0x1A, tag 0x24
    issue(32'h0001_2340, 1'b1, 0, 9'h0, 0, a);
    chk("hit_lut_addr", lut_addr, 6'h1A);
    chk("hit_lut_data", lut_data, 21'h24);
    goto(a + 3);
    chk("hit_resolve_no_req", lut_req, 1'b0);
    chk("hit_resolve_addr", lut_addr, 6'h1A);
    goto(a + 4);
    chk("hit_done", {rsp_done, rsp_hit}, 2'b11);

    // Miss on same address: grant after 3 waiting cycles, 8 beats with one gap
    issue(32'h0001_2340, 1'b0, 3, 9'b1_1110_1111, 8, a);
    chk("miss_last_cd_we", cd_we, 1'b1);
    chk("miss_last_cd_addr", cd_addr, 9'h0D7);
    chk("miss_not_done_yet", rsp_done, 1'b0);
    step();
    chk("miss_done", {rsp_done, rsp_hit}, 2'b10);

    // Back-to-back hits, boundary indices and tags
    issue(32'hFFFF_FFFF, 1'b1, 0, 9'h0, 0, a);
    t = a;
    issue(32'h0000_0000, 1'b1, 0, 9'h0, 0, a);
    chk("b2b_gap", 64'(a - t), 64'd5);
    issue(32'h8000_0420, 1'b1, 0, 9'h0, 0, a);
    chk("b2b_lut_data", lut_data, 21'h10_0000);
    chk("b2b_lut_addr", lut_addr, 6'h21);

    // Invalidate and request together in IDLE
    goto(idle_at);
    t = cyc;
    exp_clr = t;
    inv_req = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0000_1234;
    #1;
    chk("inv_clear", lut_clear, 1'b1);
    chk("inv_ready_low", req_ready, 1'b0);
    step();
    inv_req = 1'b0;
    idle_at = t + 65;
    goto(t + 64);
    chk("inv_ready_still_low", req_ready, 1'b0);
    issue(32'h0000_1234, 1'b1, 0, 9'h0, 0, a);

    // Miss interrupted by reset after 4 beats
    issue(32'h0ABC_DE60, 1'b0, 0, 9'h1FF, 4, a);
    chk("abort_cd_we_before", cd_we, 1'b1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_ctrl_outs", {req_ready, rsp_done, rsp_hit, lut_clear, lut_req, mem_req, cd_we}, 7'b0);
    chk("abort_addr_outs", {lut_addr, lut_data, mem_addr, cd_addr}, 68'h0);
    step(); step();
    rst = 1'b0;
    r = cyc;
    idle_at = r + 64;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000 + 32'(k);
      step();
      chk("stray_rvalid_no_we", cd_we, 1'b0);
    end
    mem_rvalid = 1'b0;

    // Recovery: normal hit after the settle window
    issue(32'h0ABC_DE60, 1'b1, 0, 9'h0, 0, a);
    goto(a + 5);
    step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
